kbd_seg_ctrl: RTL and testbench
===============================

KBD_SEG_CTRL -- requirements
Module: kbd_seg_ctrl

Interface
REQ-001 Parameter SEG_ACTIVE_LOW, default 1, segment polarity: 1 means a 0 bit lights the segment.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 data  input  8  head byte of the keyboard receiver FIFO.
REQ-005 ready  input  1  FIFO non-empty; data is valid while high.
REQ-006 overflow  input  1  receiver FIFO overflow flag.
REQ-007 nextdata_n  output  1  active-low pop strobe to the receiver FIFO.
REQ-008 seg0..seg7  output  8 each  digit segments: bit0=a ... bit6=g, bit7=dp.
REQ-009 ovf_led  output  1  sticky overflow indicator.

Function
REQ-010 Pop FSM SHALL have three states: IDLE, POP and WAIT.
REQ-011 IDLE: when ready=1, SHALL latch data into byte_r and go to POP.
REQ-012 POP: nextdata_n SHALL be 0 for exactly this one cycle, then go to WAIT.
REQ-013 WAIT: SHALL process byte_r (REQ-014..018) for one cycle, then return to IDLE, so ready is re-sampled only after the FIFO has updated.
REQ-014 Byte 8'hE0 SHALL set ext_f; it changes nothing else.
REQ-015 Byte 8'hF0 SHALL set brk_f; it changes nothing else.
REQ-016 Any other byte with brk_f=0 is a make code:
- If held_v=0 or byte differs from held_code: SHALL set held_code=byte, held_v=1 and increment count (8-bit, FFh wraps to 00h).
- If held_v=1 and byte equals held_code: typematic repeat; SHALL leave count unchanged.
REQ-017 Any other byte with brk_f=1 is a break code:
- If byte equals held_code: SHALL clear held_v.
- Otherwise: SHALL change nothing.
REQ-018 After any non-prefix byte, ext_f and brk_f SHALL both clear.
REQ-019 Segment outputs SHALL be registered and reflect the state in the cycle after WAIT (3 cycles after the pop decision).
REQ-020 seg1:seg0 SHALL show held_code in hex and seg3:seg2 the ASCII code from the lookup (00 when unmapped); seg0..seg3 SHALL all be blank while held_v=0.
REQ-021 seg5:seg4 SHALL always be blank.
REQ-022 seg7:seg6 SHALL always show count in hex.
REQ-023 Hex glyphs SHALL be 0-9 and A-F (b, d lowercase) with dp off; blank is 8'hFF when SEG_ACTIVE_LOW=1, or the bitwise inverse otherwise.
REQ-024 ovf_led SHALL be set whenever overflow=1 and stay set until reset.
REQ-025 With ready=0 the FSM SHALL remain in IDLE with nextdata_n=1.

Reset
REQ-026 With rst=1 at an edge, regardless of state (including mid-POP), the next cycle SHALL have: state IDLE, nextdata_n=1, ext_f=brk_f=held_v=0, count=00h, ovf_led=0.
REQ-027 In that same next cycle the segments SHALL be: seg0..seg5 blank, seg6=seg7="0" (8'hC0 active-low).
REQ-028 rst SHALL take priority over every other event in the same cycle.

Structure
REQ-029 The shared package SHALL hold: the FSM state encoding, constants E0h/F0h, the blank value and the 16-entry hex glyph table.
REQ-030 Scancode-to-ASCII SHALL be a separate combinational sub-module, scancode_to_ascii.
REQ-031 scancode_to_ascii SHALL map set-2 codes for a-z (lowercase) and 0-9, with all other codes mapping to 00h.

Verification
REQ-032 Feed 1C, F0, 1C → while held: seg1:0 "1C", seg3:2 "61", seg7:6 "01"; after break: seg0..3 blank, count remains 01.
REQ-033 Feed 1C,1C,1C,F0,1C → count=01; exactly 5 nextdata_n pulses, each 1 cycle wide and at least 3 cycles apart.
REQ-034 Feed E0, 75, E0, F0, 75 → seg1:0 "75", seg3:2 "00", count 01, then seg0..3 blank.
REQ-035 Feed 256 alternating distinct makes 1C/32 (no breaks) → count wraps to 00; seg7:6 "00".
REQ-036 Assert rst during POP with count=05 → next cycle: nextdata_n=1, count 00, seg0..5 = FF.
REQ-037 Pulse overflow=1 for 1 cycle → ovf_led=1 until the next rst.

Source files
------------

// File: rtl/kbd_seg_ctrl_pkg.sv
// Shared types and constants for the keyboard-to-seven-segment controller:
// pop FSM encoding, scancode prefixes and active-low hex glyphs.
package kbd_seg_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_WAIT = 2'd2
  } pop_state_t;

  localparam logic [7:0] CODE_EXT  = 8'hE0;
  localparam logic [7:0] CODE_BRK  = 8'hF0;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low glyphs, bit0=a .. bit6=g, bit7=dp (off)
  localparam logic [7:0] HEX_GLYPH [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic logic [7:0] seg_glyph(input logic [3:0] nib, input bit active_low);
    return active_low ? HEX_GLYPH[nib] : ~HEX_GLYPH[nib];
  endfunction

  function automatic logic [7:0] seg_blank(input bit active_low);
    return active_low ? SEG_BLANK : ~SEG_BLANK;
  endfunction

endpackage

// File: rtl/scancode_to_ascii.sv
// Combinational PS/2 set-2 scancode to ASCII lookup for a-z (lowercase)
// and 0-9; every other code yields 8'h00.
module scancode_to_ascii (
  input  logic [7:0] code,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = 8'h00;
    case (code)
      8'h1C: ascii = 8'h61; // a
      8'h32: ascii = 8'h62;
      8'h21: ascii = 8'h63;
      8'h23: ascii = 8'h64;
      8'h24: ascii = 8'h65;
      8'h2B: ascii = 8'h66;
      8'h34: ascii = 8'h67;
      8'h33: ascii = 8'h68;
      8'h43: ascii = 8'h69;
      8'h3B: ascii = 8'h6A;
      8'h42: ascii = 8'h6B;
      8'h4B: ascii = 8'h6C;
      8'h3A: ascii = 8'h6D;
      8'h31: ascii = 8'h6E;
      8'h44: ascii = 8'h6F;
      8'h4D: ascii = 8'h70;
      8'h15: ascii = 8'h71;
      8'h2D: ascii = 8'h72;
      8'h1B: ascii = 8'h73;
      8'h2C: ascii = 8'h74;
      8'h3C: ascii = 8'h75;
      8'h2A: ascii = 8'h76;
      8'h1D: ascii = 8'h77;
      8'h22: ascii = 8'h78;
      8'h35: ascii = 8'h79;
      8'h1A: ascii = 8'h7A; // z
      8'h45: ascii = 8'h30; // 0
      8'h16: ascii = 8'h31;
      8'h1E: ascii = 8'h32;
      8'h26: ascii = 8'h33;
      8'h25: ascii = 8'h34;
      8'h2E: ascii = 8'h35;
      8'h36: ascii = 8'h36;
      8'h3D: ascii = 8'h37;
      8'h3E: ascii = 8'h38;
      8'h46: ascii = 8'h39; // 9
      default: ascii = 8'h00;
    endcase
  end

endmodule

// File: rtl/kbd_seg_ctrl.sv
// Pops scancodes from the keyboard receiver FIFO, tracks the held key and a
// make counter, and drives eight registered seven-segment digits.
// FIFO handshake: data is valid while ready=1; a byte is consumed by holding
// nextdata_n low for exactly one cycle, and ready is not re-sampled until the
// FIFO has had a full cycle to present its next head.
module kbd_seg_ctrl
  import kbd_seg_ctrl_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       ready,
  input  logic       overflow,
  output logic       nextdata_n,
  output logic [7:0] seg0,
  output logic [7:0] seg1,
  output logic [7:0] seg2,
  output logic [7:0] seg3,
  output logic [7:0] seg4,
  output logic [7:0] seg5,
  output logic [7:0] seg6,
  output logic [7:0] seg7,
  output logic       ovf_led,
  output pop_state_t state_dbg
);

  localparam logic [7:0] BLANK = seg_blank(SEG_ACTIVE_LOW);

  pop_state_t state, state_n;
  logic [7:0] byte_r;
  logic [7:0] held_code, held_code_n;
  logic [7:0] count, count_n;
  logic       held_v, held_v_n;
  logic       ext_f, ext_n;
  logic       brk_f, brk_n;
  logic [7:0] ascii;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    nextdata_n = 1'b1;
    case (state)
      ST_IDLE: if (ready) state_n = ST_POP;
      ST_POP: begin
        nextdata_n = 1'b0;
        state_n    = ST_WAIT;
      end
      ST_WAIT: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                          byte_r <= 8'h00;
    else if (state == ST_IDLE && ready) byte_r <= data;
  end

  // Scancode interpretation happens only in WAIT, once per popped byte
  always_comb begin
    held_code_n = held_code;
    held_v_n    = held_v;
    count_n     = count;
    ext_n       = ext_f;
    brk_n       = brk_f;
    if (state == ST_WAIT) begin
      if (byte_r == CODE_EXT) begin
        ext_n = 1'b1;
      end else if (byte_r == CODE_BRK) begin
        brk_n = 1'b1;
      end else begin
        if (!brk_f) begin
          if (!held_v || byte_r != held_code) begin
            held_code_n = byte_r;
            held_v_n    = 1'b1;
            count_n     = count + 8'd1;
          end
        end else if (byte_r == held_code) begin
          held_v_n = 1'b0;
        end
        ext_n = 1'b0;
        brk_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held_code <= 8'h00;
      held_v    <= 1'b0;
      count     <= 8'h00;
      ext_f     <= 1'b0;
      brk_f     <= 1'b0;
    end else begin
      held_code <= held_code_n;
      held_v    <= held_v_n;
      count     <= count_n;
      ext_f     <= ext_n;
      brk_f     <= brk_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           ovf_led <= 1'b0;
    else if (overflow) ovf_led <= 1'b1;
  end

  scancode_to_ascii u_ascii (
    .code  (held_code),
    .ascii (ascii)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      seg0 <= BLANK;
      seg1 <= BLANK;
      seg2 <= BLANK;
      seg3 <= BLANK;
      seg4 <= BLANK;
      seg5 <= BLANK;
      seg6 <= seg_glyph(4'h0, SEG_ACTIVE_LOW);
      seg7 <= seg_glyph(4'h0, SEG_ACTIVE_LOW);
    end else begin
      seg0 <= held_v ? seg_glyph(held_code[3:0], SEG_ACTIVE_LOW) : BLANK;
      seg1 <= held_v ? seg_glyph(held_code[7:4], SEG_ACTIVE_LOW) : BLANK;
      seg2 <= held_v ? seg_glyph(ascii[3:0], SEG_ACTIVE_LOW) : BLANK;
      seg3 <= held_v ? seg_glyph(ascii[7:4], SEG_ACTIVE_LOW) : BLANK;
      seg4 <= BLANK;
      seg5 <= BLANK;
      seg6 <= seg_glyph(count[3:0], SEG_ACTIVE_LOW);
      seg7 <= seg_glyph(count[7:4], SEG_ACTIVE_LOW);
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_kbd_seg_ctrl.sv
// Self-checking bench for kbd_seg_ctrl: a FIFO model feeds scancodes and a
// per-byte reference model predicts the eight digit outputs.
module tb_kbd_seg_ctrl;
  import kbd_seg_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic       ready = 1'b0;
  logic       overflow = 1'b0;
  logic       nextdata_n, ovf_led;
  logic [7:0] seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;
  pop_state_t state_dbg;

  int checks = 0;
  int errors = 0;

  logic [7:0]  fifo_q[$];
  logic [63:0] exp_q[$];

  // Pulse monitor
  int   cyc = 0;
  int   pulses = 0;
  int   width_viol = 0;
  int   gap_viol = 0;
  int   last_pulse = -100;
  logic prev_low = 1'b0;

  // Reference model
  bit         m_brk, m_held_v;
  logic [7:0] m_held;
  int         m_count;
  logic [7:0] ascii_of [logic [7:0]];
  logic [7:0] glyph_lut [16];
  logic [7:0] key_codes [36];

  always #5 clk = ~clk;

  kbd_seg_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow),
    .nextdata_n (nextdata_n),
    .seg0       (seg0),
    .seg1       (seg1),
    .seg2       (seg2),
    .seg3       (seg3),
    .seg4       (seg4),
    .seg5       (seg5),
    .seg6       (seg6),
    .seg7       (seg7),
    .ovf_led    (ovf_led),
    .state_dbg  (state_dbg)
  );

  // FIFO model: pops on a low nextdata_n, presents head on negedge
  always @(negedge clk) begin
    cyc++;
    if (!nextdata_n) begin
      pulses++;
      if (prev_low) width_viol++;
      if (cyc - last_pulse < 3) gap_viol++;
      last_pulse = cyc;
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
    end
    prev_low = !nextdata_n;
    ready = (fifo_q.size() != 0);
    data  = ready ? fifo_q[0] : 8'h00;
  end

  function automatic void model_reset();
    m_brk = 1'b0; m_held_v = 1'b0; m_held = 8'h00; m_count = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (b == 8'hF0) m_brk = 1'b1;
    else if (b != 8'hE0) begin
      if (!m_brk) begin
        if (!m_held_v || b != m_held) begin
          m_held = b; m_held_v = 1'b1; m_count = (m_count + 1) % 256;
        end
      end else if (b == m_held) m_held_v = 1'b0;
      m_brk = 1'b0;
    end
  endfunction

  function automatic logic [63:0] exp_segs();
    logic [63:0] r;
    logic [7:0]  a, c;
    a = ascii_of.exists(m_held) ? ascii_of[m_held] : 8'h00;
    c = m_count[7:0];
    r[7:0]   = m_held_v ? glyph_lut[m_held[3:0]] : 8'hFF;
    r[15:8]  = m_held_v ? glyph_lut[m_held[7:4]] : 8'hFF;
    r[23:16] = m_held_v ? glyph_lut[a[3:0]] : 8'hFF;
    r[31:24] = m_held_v ? glyph_lut[a[7:4]] : 8'hFF;
    r[47:32] = 16'hFFFF;
    r[55:48] = glyph_lut[c[3:0]];
    r[63:56] = glyph_lut[c[7:4]];
    return r;
  endfunction

  function automatic logic [63:0] act_segs();
    return {seg7, seg6, seg5, seg4, seg3, seg2, seg1, seg0};
  endfunction

  task automatic do_reset();
    fifo_q.delete();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic feed(input logic [7:0] b);
    fifo_q.push_back(b);
    model_byte(b);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (fifo_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (fifo_q.size() != 0) begin
      errors++;
      $display("FAIL %s drain timeout: %0d bytes left, required 0", name, fifo_q.size());
      fifo_q.delete();
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (act_segs() !== 64'hC0C0_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL reset_segs: got %h, required %h", act_segs(), 64'hC0C0_FFFF_FFFF_FFFF);
    end
    checks++;
    if (nextdata_n !== 1'b1) begin
      errors++; $display("FAIL reset_nextdata_n: got %b, required 1", nextdata_n);
    end
    checks++;
    if (ovf_led !== 1'b0) begin
      errors++; $display("FAIL reset_ovf_led: got %b, required 0", ovf_led);
    end
    checks++;
    if (state_dbg !== ST_IDLE) begin
      errors++; $display("FAIL reset_state: got %0d, required %0d", state_dbg, ST_IDLE);
    end
  endtask

  task automatic test_idle_no_ready();
    int bad = 0;
    do_reset();
    repeat (20) begin
      @(negedge clk);
      if (nextdata_n !== 1'b1 || state_dbg !== ST_IDLE) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL idle_no_ready: %0d cycles left IDLE or popped, required 0", bad);
    end
  endtask

  task automatic test_make_break();
    do_reset();
    feed(8'h1C);
    drain("make_1c");
    checks++;
    if (act_segs() !== 64'hC0F9_FFFF_82F9_F9C6) begin
      errors++; $display("FAIL make_1c: got %h, required %h", act_segs(), 64'hC0F9_FFFF_82F9_F9C6);
    end
    feed(8'hF0); feed(8'h1C);
    drain("break_1c");
    checks++;
    if (act_segs() !== 64'hC0F9_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL break_1c: got %h, required %h", act_segs(), 64'hC0F9_FFFF_FFFF_FFFF);
    end
  endtask

  task automatic test_typematic();
    int p0, w0, g0;
    do_reset();
    p0 = pulses; w0 = width_viol; g0 = gap_viol;
    feed(8'h1C); feed(8'h1C); feed(8'h1C); feed(8'hF0); feed(8'h1C);
    drain("typematic");
    checks++;
    if (pulses - p0 != 5) begin
      errors++; $display("FAIL typematic_pulses: got %0d, required 5", pulses - p0);
    end
    checks++;
    if (width_viol - w0 != 0 || gap_viol - g0 != 0) begin
      errors++; $display("FAIL typematic_spacing: width %0d gap %0d violations, required 0",
                         width_viol - w0, gap_viol - g0);
    end
    checks++;
    if (act_segs() !== exp_segs()) begin
      errors++; $display("FAIL typematic_segs: got %h, required %h", act_segs(), exp_segs());
    end
  endtask

  task automatic test_extended();
    do_reset();
    feed(8'hE0); feed(8'h75);
    drain("ext_make");
    checks++;
    if (act_segs() !== 64'hC0F9_FFFF_C0C0_F892) begin
      errors++; $display("FAIL ext_make: got %h, required %h", act_segs(), 64'hC0F9_FFFF_C0C0_F892);
    end
    feed(8'hE0); feed(8'hF0); feed(8'h75);
    drain("ext_break");
    checks++;
    if (act_segs() !== 64'hC0F9_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL ext_break: got %h, required %h", act_segs(), 64'hC0F9_FFFF_FFFF_FFFF);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 256; i++) feed((i % 2 == 1) ? 8'h32 : 8'h1C);
    drain("wrap");
    checks++;
    if (act_segs() !== 64'hC0C0_FFFF_82A4_B0A4) begin
      errors++; $display("FAIL wrap: got %h, required %h", act_segs(), 64'hC0C0_FFFF_82A4_B0A4);
    end
    checks++;
    if (act_segs() !== exp_segs()) begin
      errors++; $display("FAIL wrap_model: got %h, required %h", act_segs(), exp_segs());
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [6];
    logic [63:0] e;
    pool = '{8'h1C, 8'h32, 8'h45, 8'h16, 8'h1A, 8'h2B};
    do_reset();
    for (int r = 0; r < 25; r++) begin
      int n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++) begin
        int k = $urandom_range(0, 9);
        if (k == 0)      feed(8'hE0);
        else if (k == 1) feed(8'hF0);
        else if (k < 8)  feed(pool[$urandom_range(0, 5)]);
        else             feed(8'($urandom_range(0, 255)));
      end
      drain("random");
      exp_q.push_back(exp_segs());
      e = exp_q.pop_front();
      checks++;
      if (act_segs() !== e) begin
        errors++; $display("FAIL random_round%0d: got %h, required %h", r, act_segs(), e);
      end
    end
  endtask

  task automatic test_reset_mid_pop();
    int n = 0;
    do_reset();
    feed(8'h1C); feed(8'h32); feed(8'h21); feed(8'h23); feed(8'h24);
    drain("pre_mid_pop");
    checks++;
    if (act_segs() !== exp_segs()) begin
      errors++; $display("FAIL count5_segs: got %h, required %h", act_segs(), exp_segs());
    end
    fifo_q.push_back(8'h2D);
    while (nextdata_n !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (nextdata_n !== 1'b0) begin
      errors++; $display("FAIL mid_pop_reach: nextdata_n %b after %0d cycles, required 0", nextdata_n, n);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (nextdata_n !== 1'b1 || state_dbg !== ST_IDLE) begin
      errors++; $display("FAIL mid_pop_reset: nextdata_n %b state %0d, required 1 and %0d",
                         nextdata_n, state_dbg, ST_IDLE);
    end
    @(negedge clk);
    checks++;
    if (act_segs() !== 64'hC0C0_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL mid_pop_segs: got %h, required %h", act_segs(), 64'hC0C0_FFFF_FFFF_FFFF);
    end
    fifo_q.delete();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_overflow();
    do_reset();
    checks++;
    if (ovf_led !== 1'b0) begin
      errors++; $display("FAIL ovf_pre: got %b, required 0", ovf_led);
    end
    overflow = 1'b1;
    @(negedge clk);
    overflow = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ovf_led !== 1'b1) begin
      errors++; $display("FAIL ovf_set: got %b, required 1", ovf_led);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (ovf_led !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky: got %b, required 1", ovf_led);
    end
    do_reset();
    checks++;
    if (ovf_led !== 1'b0) begin
      errors++; $display("FAIL ovf_cleared: got %b, required 0", ovf_led);
    end
  endtask

  initial begin
    string keys;
    keys = "abcdefghijklmnopqrstuvwxyz0123456789";
    key_codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                  8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                  8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
                  8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    for (int i = 0; i < 36; i++) ascii_of[key_codes[i]] = keys[i];
    glyph_lut = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    model_reset();

    test_reset();
    test_idle_no_ready();
    test_make_break();
    test_typematic();
    test_extended();
    test_wrap();
    test_random();
    test_reset_mid_pop();
    test_overflow();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
